// File: rtl/ofdm_ifft_feeder.sv
`default_nettype none
// ============================================================================
// Module   : ofdm_ifft_feeder
// Purpose  : Collects 48 data points per OFDM symbol, inserts 4 pilots and
//            12 nulls, and streams the 64-bin symbol to the IFFT as one burst.
//            Optional PILOT_SCRAMBLE_EN adds per-symbol pilot polarity (LFSR).
// Revision : 1.0
// ============================================================================
module ofdm_ifft_feeder #(
    parameter logic signed [10:0] PILOT_AMP = 11'sd256,
    parameter int unsigned        GAP       = 0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               valid_d,
    output logic               ready_d,
    input  logic signed [10:0] dr,
    input  logic signed [10:0] di,
    input  logic               flush,
    output logic               valid_a,
    output logic signed [10:0] ar,
    output logic signed [10:0] ai,
    output logic               sym_done,
    output logic [15:0]        sym_cnt
);

    localparam logic [1:0]         c_ST_FILL   = 2'd0;
    localparam logic [1:0]         c_ST_EMIT   = 2'd1;
    localparam logic [1:0]         c_ST_WAIT   = 2'd2;
    localparam logic [5:0]         c_LAST_DATA = 6'd47;
    localparam logic [7:0]         c_GAP_LOAD  = (GAP == 0) ? 8'd0 : 8'(GAP - 1);
    localparam logic signed [10:0] c_PILOT_NEG = -PILOT_AMP;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [5:0]         r_fcnt;
    logic [5:0]         r_bin;
    logic [7:0]         r_gap;
    logic               r_ready;
    logic               r_valid_a;
    logic               r_last;
    logic               r_sym_done;
    logic signed [10:0] r_ar;
    logic signed [10:0] r_ai;
    logic [15:0]        r_sym_cnt;
    logic [21:0]        r_buf [0:47];

    logic               w_acc;
    logic               w_close;
    logic               w_last_bin;
    logic               w_is_null;
    logic               w_is_pilot;
    logic               w_pilot_neg;
    logic               w_scr_inv;
    logic [5:0]         w_didx;
    logic [21:0]        w_dword;
    logic signed [10:0] w_bin_re;
    logic signed [10:0] w_bin_im;

    assign w_acc      = valid_d && r_ready && (r_state == c_ST_FILL);
    // Flush closes the symbol only if it would carry at least one sample.
    assign w_close    = (w_acc && (r_fcnt == c_LAST_DATA)) ||
                        (flush && (r_state == c_ST_FILL) && ((r_fcnt != 6'd0) || w_acc));
    assign w_last_bin = (r_bin == 6'd63);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_FILL: if (w_close) w_state_nxt = c_ST_EMIT;
            c_ST_EMIT: if (w_last_bin) w_state_nxt = (GAP == 0) ? c_ST_FILL : c_ST_WAIT;
            c_ST_WAIT: if (r_gap == 8'd0) w_state_nxt = c_ST_FILL;
            default:   w_state_nxt = c_ST_FILL;
        endcase
    end

    // Subcarrier map: bin index to null / pilot / data slot.
    always_comb begin
        w_is_null   = (r_bin == 6'd0) || ((r_bin >= 6'd27) && (r_bin <= 6'd37));
        w_is_pilot  = (r_bin == 6'd7) || (r_bin == 6'd21) || (r_bin == 6'd43) || (r_bin == 6'd57);
        w_pilot_neg = (r_bin == 6'd21);
        w_didx      = 6'd0;
        if (!w_is_null && !w_is_pilot) begin
            if (r_bin < 6'd7)       w_didx = r_bin - 6'd1;
            else if (r_bin < 6'd21) w_didx = r_bin - 6'd2;
            else if (r_bin < 6'd27) w_didx = r_bin - 6'd3;
            else if (r_bin < 6'd43) w_didx = r_bin - 6'd14;
            else if (r_bin < 6'd57) w_didx = r_bin - 6'd15;
            else                    w_didx = r_bin - 6'd16;
        end
    end

    // Slots beyond the fill count belong to a flushed symbol and read as zero.
    assign w_dword = (w_didx < r_fcnt) ? r_buf[w_didx] : 22'd0;

    always_comb begin
        w_bin_re = 11'sd0;
        w_bin_im = 11'sd0;
        if (w_is_pilot) begin
            w_bin_re = (w_pilot_neg ^ w_scr_inv) ? c_PILOT_NEG : PILOT_AMP;
        end else if (!w_is_null) begin
            w_bin_re = w_dword[21:11];
            w_bin_im = w_dword[10:0];
        end
    end

`ifdef PILOT_SCRAMBLE_EN
    logic [6:0] r_lfsr;

    assign w_scr_inv = r_lfsr[6] ^ r_lfsr[3];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_lfsr <= 7'b1111111;
        end else if (r_valid_a && r_last) begin
            r_lfsr <= {r_lfsr[5:0], w_scr_inv};
        end
    end
`else
    assign w_scr_inv = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (w_acc) r_buf[r_fcnt] <= {dr, di};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= c_ST_FILL;
            r_fcnt     <= 6'd0;
            r_bin      <= 6'd0;
            r_gap      <= 8'd0;
            r_ready    <= 1'b0;
            r_valid_a  <= 1'b0;
            r_last     <= 1'b0;
            r_sym_done <= 1'b0;
            r_ar       <= 11'sd0;
            r_ai       <= 11'sd0;
            r_sym_cnt  <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == c_ST_FILL);
            if (w_acc) begin
                r_fcnt <= r_fcnt + 6'd1;
            end else if ((r_state == c_ST_EMIT) && w_last_bin) begin
                r_fcnt <= 6'd0;
            end
            r_bin <= (r_state == c_ST_EMIT) ? r_bin + 6'd1 : 6'd0;
            if (r_state == c_ST_EMIT) begin
                r_gap <= c_GAP_LOAD;
            end else if ((r_state == c_ST_WAIT) && (r_gap != 8'd0)) begin
                r_gap <= r_gap - 8'd1;
            end
            r_valid_a  <= (r_state == c_ST_EMIT);
            r_last     <= (r_state == c_ST_EMIT) && w_last_bin;
            r_ar       <= (r_state == c_ST_EMIT) ? w_bin_re : 11'sd0;
            r_ai       <= (r_state == c_ST_EMIT) ? w_bin_im : 11'sd0;
            r_sym_done <= r_valid_a && r_last;
            if (r_valid_a && r_last) r_sym_cnt <= r_sym_cnt + 16'd1;
        end
    end

    assign ready_d  = r_ready;
    assign valid_a  = r_valid_a;
    assign ar       = r_ar;
    assign ai       = r_ai;
    assign sym_done = r_sym_done;
    assign sym_cnt  = r_sym_cnt;

endmodule
`default_nettype wire
